// File: rtl/mac_host_pkg.sv
// Shared state encoding, size defaults and length decoding for the MAC host sequencer.
package mac_host_pkg;

    localparam int DW_DEF         = 16;
    localparam int AW_DEF         = 8;
    localparam int DEPTH_DEF      = 256;
    localparam int TMO_CYC_DEF    = 1023;
    localparam int LEN_ZERO_MEANS = 256;

    typedef enum logic [2:0] {
        IDLE,
        CONF,
        GAP,
        STREAM,
        WAIT_RES,
        DONE
    } state_t;

    // A programmed length of zero requests a full 256-pair job.
    function automatic logic [8:0] pair_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/mac_host_buf.sv
// Dual-bank operand store: one shared write port, one combinational read index for both banks.
module mac_host_buf
    import mac_host_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b
);

    logic [DW-1:0] bank_a [DEPTH];
    logic [DW-1:0] bank_b [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel) begin
            bank_a[wr_addr] <= wr_data;
        end
        if (wr_en && wr_sel) begin
            bank_b[wr_addr] <= wr_data;
        end
    end

    assign rd_a = bank_a[rd_addr];
    assign rd_b = bank_b[rd_addr];

endmodule

// File: rtl/mac_host_seq.sv
// Host-side sequencer: configures the MAC, streams buffered operand pairs, captures the result.
// Optional result-wait timeout enabled by defining MAC_HOST_TIMEOUT_EN.
module mac_host_seq
  import mac_host_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          cfg_fp,
  input  logic [7:0]    cfg_len,
  output logic          config_en,
  output logic          float_int,
  output logic [7:0]    data_num,
  output logic [DW-1:0] in_a,
  output logic [DW-1:0] in_b,
  output logic          in_valid_a,
  output logic          in_valid_b,
  input  logic          out_valid,
  input  logic [DW-1:0] mac_out,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          err_timeout
);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] idx;
  logic [8:0]    sent;
  logic [8:0]    len_pairs;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          buf_we;
  logic          tmo_hit;

  assign buf_we = wr_en && (state == IDLE);

  mac_host_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = CONF;
      CONF:     next_state = GAP;
      GAP:      next_state = STREAM;
      STREAM:   if (sent == len_pairs) next_state = WAIT_RES;
      WAIT_RES: if (out_valid || tmo_hit) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      sent       <= '0;
      len_pairs  <= '0;
      config_en  <= 1'b0;
      float_int  <= 1'b0;
      data_num   <= '0;
      in_a       <= '0;
      in_b       <= '0;
      in_valid_a <= 1'b0;
      in_valid_b <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      state      <= next_state;
      config_en  <= (next_state == CONF);
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
      in_valid_a <= (next_state == STREAM);
      in_valid_b <= (next_state == STREAM);
      if (state == IDLE && start) begin
        float_int <= cfg_fp;
        data_num  <= cfg_len;
        len_pairs <= pair_count(cfg_len);
      end
      if (state == CONF) begin
        idx  <= '0;
        sent <= '0;
      end
      if (next_state == STREAM) begin
        in_a <= rd_a;
        in_b <= rd_b;
        idx  <= idx + AW'(1);
        sent <= sent + 9'd1;
      end
      if (state == WAIT_RES && next_state == DONE) begin
        result <= out_valid ? mac_out : '0;
      end
    end
  end

`ifdef MAC_HOST_TIMEOUT_EN
  localparam int WCW = $clog2(TMO_CYC + 1);

  logic [WCW-1:0] wait_cnt;
  logic           err_q;

  assign tmo_hit = (state == WAIT_RES) && (wait_cnt == WCW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == WAIT_RES) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == WAIT_RES && next_state == DONE) begin
        err_q <= !out_valid;
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
